// File: rtl/ula_exec.sv
// ula / ula_exec
//
// ula: combinational arithmetic/logic unit.
//   a, b   : operands (BITS)
//   op     : operation code (ULA_OP)
//            0 AND, 1 OR, 2 XOR, 3 NOT a, 4 ADD, 5 SUB (a-b),
//            6 SHL a by 1, 7 SHR a by 1, others pass a
//   result : operation result (BITS)
//
// ula_exec: wraps ula with a valid/ready request side and a 2-entry
// response FIFO holding {result, zero, carry}.
//   clk_in, rst_n_in            : clock, synchronous active-low reset
//   req_valid_in/req_ready_out  : request handshake
//   a_in, b_in, ula_op_in       : request payload, fed straight into ula
//   rsp_valid_out/rsp_ready_in  : response handshake
//   result_out/zero_out/carry_out : FIFO head entry
//   done_count_out              : wrapping count of consumed responses

module ula #(
  parameter int unsigned BITS   = 8,
  parameter int unsigned ULA_OP = 4
) (
  input  logic [BITS-1:0]   a,
  input  logic [BITS-1:0]   b,
  input  logic [ULA_OP-1:0] op,
  output logic [BITS-1:0]   result
);

  // Operation decode
  always_comb begin
    result = a;
    case (op)
      ULA_OP'(0): result = a & b;
      ULA_OP'(1): result = a | b;
      ULA_OP'(2): result = a ^ b;
      ULA_OP'(3): result = ~a;
      ULA_OP'(4): result = a + b;
      ULA_OP'(5): result = a - b;
      ULA_OP'(6): result = a << 1;
      ULA_OP'(7): result = a >> 1;
      default:    result = a;
    endcase
  end

endmodule

module ula_exec #(
  parameter int unsigned BITS   = 8,
  parameter int unsigned ULA_OP = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic [BITS-1:0]   a_in,
  input  logic [BITS-1:0]   b_in,
  input  logic [ULA_OP-1:0] ula_op_in,
  output logic              rsp_valid_out,
  input  logic              rsp_ready_in,
  output logic [BITS-1:0]   result_out,
  output logic              zero_out,
  output logic              carry_out,
  output logic [15:0]       done_count_out
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [BITS-1:0] result;
    logic            zero;
    logic            carry;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic             wr_ptr;
  logic             rd_ptr;

  logic [BITS-1:0]  ula_result;
  logic             add_carry;
  logic [BITS-1:0]  sum_unused;
  logic             push;
  logic             pop;
  entry_t           new_entry;
  entry_t           head;

  ula #(
    .BITS   (BITS),
    .ULA_OP (ULA_OP)
  ) u_ula (
    .a      (a_in),
    .b      (b_in),
    .op     (ula_op_in),
    .result (ula_result)
  );

  // Carry-out of a+b, only meaningful for the add opcode
  assign {add_carry, sum_unused} = {1'b0, a_in} + {1'b0, b_in};

  assign req_ready_out = (count != CNT_W'(DEPTH));
  assign rsp_valid_out = (count != '0);
  assign push          = req_valid_in && req_ready_out;
  assign pop           = rsp_ready_in && rsp_valid_out;

  always_comb begin
    new_entry        = '0;
    new_entry.result = ula_result;
    new_entry.zero   = (ula_result == '0);
    new_entry.carry  = (ula_op_in == ULA_OP'(4)) ? add_carry : 1'b0;
  end

  assign head       = mem[rd_ptr];
  assign result_out = head.result;
  assign zero_out   = head.zero;
  assign carry_out  = head.carry;

  // FIFO storage, pointers, occupancy and consumed-response counter
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      mem[0]         <= '0;
      mem[1]         <= '0;
      count          <= '0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      done_count_out <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr         <= ~rd_ptr;
        done_count_out <= done_count_out + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/ula_exec.md
ULA_EXEC -- requirements
Module: ula_exec

Interface
REQ-001 SHALL have parameter BITS, default 8, the operand/result width.
REQ-002 SHALL have parameter ULA_OP, default 4, the width of the operation code.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_in, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port req_valid_in, input, 1, request present.
REQ-006 SHALL have port req_ready_out, output, 1, request can be accepted.
REQ-007 SHALL have port a_in, input, BITS, operand A.
REQ-008 SHALL have port b_in, input, BITS, operand B.
REQ-009 SHALL have port ula_op_in, input, ULA_OP, operation code passed unmodified to the ula.
REQ-010 SHALL have port rsp_valid_out, output, 1, response present.
REQ-011 SHALL have port rsp_ready_in, input, 1, consumer takes the response.
REQ-012 SHALL have port result_out, output, BITS, response result.
REQ-013 SHALL have port zero_out, output, 1, response result equals 0.
REQ-014 SHALL have port carry_out, output, 1, response carry, add only.
REQ-015 SHALL have port done_count_out, output, 16, count of responses consumed.

Function
REQ-016 SHALL instantiate the existing ula module, driving a_in, b_in and ula_op_in directly into it, as the sole source of result values.
REQ-017 SHALL accept a request on any rising edge where req_valid_in and req_ready_out are both 1 ("push").
REQ-018 SHALL deliver a response on any rising edge where rsp_valid_out and rsp_ready_in are both 1 ("pop").
REQ-019 SHALL buffer responses in a 2-entry FIFO, with count in {0,1,2}, and each entry holding {result, zero, carry}.
REQ-020 SHALL drive req_ready_out = (count != 2), registered-state only, with no combinational path from rsp_ready_in.
REQ-021 SHALL drive rsp_valid_out = (count != 0).
REQ-022 SHALL drive result_out/zero_out/carry_out from the FIFO head entry.
REQ-023 SHALL hold the head outputs stable while rsp_valid_out=1 and rsp_ready_in=0.
REQ-024 SHALL, on push, capture the ula result, zero = (result == 0), and carry = bit BITS of the (BITS+1)-bit sum a_in+b_in when ula_op_in == 4, else 0.
REQ-025 SHALL have a latency of 1 cycle: a push at edge N gives rsp_valid_out=1 after edge N when the FIFO was empty.
REQ-026 SHALL, on simultaneous push and pop, leave count unchanged; a new entry goes behind the remaining one; at count 1 the pushed entry becomes head.
REQ-027 SHALL ignore push attempts while count==2 (req_ready_out=0); the request is not stored and FIFO contents are unchanged.
REQ-028 SHALL ignore rsp_ready_in while count==0, with no underflow and no counter change.
REQ-029 SHALL preserve FIFO order strictly (first in, first out), using 1-bit read and write pointers that wrap modulo 2.
REQ-030 SHALL increment done_count_out by 1 on each pop, wrapping from 0xFFFF to 0x0000.
REQ-031 SHALL ignore X-free operands on non-push cycles; the FIFO is not modified.

Reset
REQ-032 SHALL, when rst_n_in=0 at a rising edge, set count=0, pointers=0, done_count_out=0, result_out=0, zero_out=0, carry_out=0, rsp_valid_out=0, and req_ready_out=1 after that edge.
REQ-033 SHALL give reset priority over push and pop in the same cycle; entries in flight are discarded.
REQ-034 SHALL resume normal operation on the first edge with rst_n_in=1.

Verification
REQ-035 SHALL cover single add: reset, push a=0x05 b=0x03 op=4, rsp_ready_in=1 -> next cycle rsp_valid=1, result=0x08, zero=0, carry=0; after pop, done_count=1.
REQ-036 SHALL cover add wrap: push a=0xFF b=0x01 op=4 -> result=0x00, zero=1, carry=1; push a=0x80 b=0x80 op=4 -> result=0x00, carry=1.
REQ-037 SHALL cover backpressure: rsp_ready_in=0, push (1,2) then (3,4) -> req_ready_out=0 after the 2nd push; a 3rd push (9,9) is ignored; then rsp_ready_in=1 -> results 0x03, 0x07 in order, and done_count=2.
REQ-038 SHALL cover streaming: req_valid=1 and rsp_ready=1 continuously for 256 adds a=k, b=k -> one response per cycle after the first; result=(2k) mod 256; carry=1 for k>=128.
REQ-039 SHALL cover mid-operation reset: with 2 entries buffered, assert rst_n_in=0 for 1 cycle together with push and pop -> rsp_valid=0, req_ready=1, done_count=0, and the old entries are never output.
REQ-040 SHALL cover counter wrap: force 65536 pops -> done_count_out returns to 0x0000.
